// File: rtl/half_pkg.sv
// Shared binary16 types, constants, classification helpers and the FSM state
// encoding used by the half-precision pipeline stages.
package half_pkg;

  typedef logic [15:0] half_t;

  localparam half_t HALF_ZERO     = 16'h0000;
  localparam half_t HALF_NEG_ZERO = 16'h8000;
  localparam half_t HALF_QNAN     = 16'h7E00;
  localparam half_t HALF_POS_INF  = 16'h7C00;
  localparam half_t HALF_NEG_INF  = 16'hFC00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_nan(input half_t x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  function automatic logic is_inf(input half_t x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
  endfunction

  // Subnormals carry no weight in this datapath, so they count as zero.
  function automatic logic is_zero(input half_t x);
    return (x[14:10] == 5'h00);
  endfunction

  // Leading-zero count of a 14-bit value; only meaningful for a nonzero input.
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) begin
        n = 4'(13 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/half_add.sv
// Combinational binary16 adder: round-to-nearest-even, subnormal inputs treated
// as signed zero, subnormal results flushed to +0, exact cancellation gives +0.
module half_add
  import half_pkg::*;
(
  input  half_t a,
  input  half_t b,
  output half_t c
);

  logic              w_swap;
  half_t             w_big;
  half_t             w_small;
  logic              w_eff_sub;
  logic [4:0]        w_exp_diff;
  logic [13:0]       w_man_big;
  logic [13:0]       w_man_sml_pre;
  logic [13:0]       w_man_sml;
  logic [14:0]       w_sum;
  logic [3:0]        w_lz;
  logic [13:0]       w_norm;
  logic signed [6:0] w_exp_norm;
  logic              w_rnd_up;
  logic [11:0]       w_man_rnd;
  logic signed [6:0] w_exp_rnd;
  logic [9:0]        w_frac_rnd;
  half_t             w_c;

  assign w_swap    = (b[14:0] > a[14:0]);
  assign w_big     = w_swap ? b : a;
  assign w_small   = w_swap ? a : b;
  assign w_eff_sub = w_big[15] ^ w_small[15];

  // Align the smaller operand; three extra low bits hold guard, round and sticky.
  always_comb begin
    w_exp_diff    = w_big[14:10] - w_small[14:10];
    w_man_big     = {1'b1, w_big[9:0], 3'b000};
    w_man_sml_pre = {1'b1, w_small[9:0], 3'b000};
    if (w_exp_diff > 5'd13) begin
      w_man_sml = 14'd1;
    end else begin
      w_man_sml = (w_man_sml_pre >> w_exp_diff)
                | {13'd0, |(w_man_sml_pre & ((14'd1 << w_exp_diff) - 14'd1))};
    end
    if (w_eff_sub) begin
      w_sum = {1'b0, w_man_big} - {1'b0, w_man_sml};
    end else begin
      w_sum = {1'b0, w_man_big} + {1'b0, w_man_sml};
    end
  end

  always_comb begin
    w_lz = lzc14(w_sum[13:0]);
    if (w_sum[14]) begin
      w_norm     = {w_sum[14:2], w_sum[1] | w_sum[0]};
      w_exp_norm = $signed({2'b00, w_big[14:10]}) + 7'sd1;
    end else begin
      w_norm     = w_sum[13:0] << w_lz;
      w_exp_norm = $signed({2'b00, w_big[14:10]}) - $signed({3'b000, w_lz});
    end
    w_rnd_up   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_man_rnd  = {1'b0, w_norm[13:3]} + {11'd0, w_rnd_up};
    w_exp_rnd  = w_exp_norm + (w_man_rnd[11] ? 7'sd1 : 7'sd0);
    w_frac_rnd = w_man_rnd[11] ? w_man_rnd[10:1] : w_man_rnd[9:0];
  end

  // Special operands take priority over the normal datapath result.
  always_comb begin
    w_c = HALF_ZERO;
    if (is_nan(a) || is_nan(b)) begin
      w_c = HALF_QNAN;
    end else if (is_inf(a) && is_inf(b) && (a[15] != b[15])) begin
      w_c = HALF_QNAN;
    end else if (is_inf(a)) begin
      w_c = a;
    end else if (is_inf(b)) begin
      w_c = b;
    end else if (is_zero(a) && is_zero(b)) begin
      w_c = {a[15] & b[15], 15'd0};
    end else if (is_zero(a)) begin
      w_c = b;
    end else if (is_zero(b)) begin
      w_c = a;
    end else if (w_sum == 15'd0) begin
      w_c = HALF_ZERO;
    end else if (w_exp_rnd >= 7'sd31) begin
      w_c = {w_big[15], HALF_POS_INF[14:0]};
    end else if (w_exp_rnd <= 7'sd0) begin
      w_c = HALF_ZERO;
    end else begin
      w_c = {w_big[15], w_exp_rnd[4:0], w_frac_rnd};
    end
  end

  assign c = w_c;

endmodule

// File: rtl/half_bias_act.sv
// Bias-add and activation stage: captures a result vector and bias, then writes
// act(vin + bias) one element per cycle. Define HALF_BIAS_LEAKY_EN for leaky ReLU.
module half_bias_act
  import half_pkg::*;
#(
  parameter int HEIGHT = 10
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  half_t vector_in  [HEIGHT],
  input  half_t bias       [HEIGHT],
  output logic  done,
  output half_t vector_out [HEIGHT]
);

  localparam int                 IDX_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(HEIGHT - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_done;
  half_t            r_vin  [HEIGHT];
  half_t            r_bias [HEIGHT];
  half_t            r_out  [HEIGHT];

  logic             w_capture;
  logic             w_write;
  logic             w_done_nxt;
  logic             w_last;
  half_t            w_add_a;
  half_t            w_add_b;
  half_t            w_sum;
  half_t            w_act;

  function automatic half_t act_fn(input half_t x);
    half_t y;
    if (is_nan(x)) begin
      y = HALF_QNAN;
`ifdef HALF_BIAS_LEAKY_EN
    end else if (x == HALF_NEG_INF) begin
      y = HALF_NEG_INF;
    end else if (x[15]) begin
      // Slope 1/8 is an exponent decrement; anything that would go subnormal is -0.
      y = (x[14:10] <= 5'd3) ? HALF_NEG_ZERO : {1'b1, x[14:10] - 5'd3, x[9:0]};
`else
    end else if (x[15]) begin
      y = HALF_ZERO;
`endif
    end else begin
      y = x;
    end
    return y;
  endfunction

  assign w_last  = (r_idx == LAST_IDX);
  assign w_add_a = r_vin[r_idx];
  assign w_add_b = r_bias[r_idx];

  half_add u_add (
    .a (w_add_a),
    .b (w_add_b),
    .c (w_sum)
  );

  assign w_act = act_fn(w_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_write     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        w_write = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // done is registered off the DONE state, so it rises one edge after the last write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_done <= 1'b0;
      for (int i = 0; i < HEIGHT; i++) begin
        r_vin[i]  <= HALF_ZERO;
        r_bias[i] <= HALF_ZERO;
        r_out[i]  <= HALF_ZERO;
      end
    end else begin
      r_done <= w_done_nxt;
      if (w_capture) begin
        r_idx <= '0;
        for (int i = 0; i < HEIGHT; i++) begin
          r_vin[i]  <= vector_in[i];
          r_bias[i] <= bias[i];
        end
      end else if (w_write) begin
        r_out[r_idx] <= w_act;
        r_idx        <= w_last ? '0 : (r_idx + IDX_ONE);
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  assign done       = r_done;
  assign vector_out = r_out;

endmodule

// File: tb/tb_half_bias_act.sv
// Directed self-checking bench for half_bias_act (HEIGHT = 4 and HEIGHT = 1 instances).
module tb_half_bias_act;

  logic        clk;
  logic        rst;
  logic        start4;
  logic        start1;
  logic        done4;
  logic        done1;
  logic [15:0] vin4  [4];
  logic [15:0] bias4 [4];
  logic [15:0] out4  [4];
  logic [15:0] vin1  [1];
  logic [15:0] bias1 [1];
  logic [15:0] out1  [1];

  int n_err;
  int n_chk;

`ifdef HALF_BIAS_LEAKY_EN
  localparam logic [15:0] NEG_M1 = 16'hB000;
  localparam logic [15:0] NEG_M4 = 16'hB800;
`else
  localparam logic [15:0] NEG_M1 = 16'h0000;
  localparam logic [15:0] NEG_M4 = 16'h0000;
`endif

  half_bias_act #(.HEIGHT(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .vector_in  (vin4),
    .bias       (bias4),
    .done       (done4),
    .vector_out (out4)
  );

  half_bias_act #(.HEIGHT(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .vector_in  (vin1),
    .bias       (bias1),
    .done       (done1),
    .vector_out (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_out4(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
    chk({tag, "_out0"}, out4[0], e0);
    chk({tag, "_out1"}, out4[1], e1);
    chk({tag, "_out2"}, out4[2], e2);
    chk({tag, "_out3"}, out4[3], e3);
  endtask

  // Cycle c is sampled at the falling edge after rising edge E(c) following the start edge.
  task automatic watch4(input string tag, input int c_from, input int c_to,
                        input int d1, input int d2);
    for (int c = c_from; c <= c_to; c++) begin
      @(negedge clk);
      chk($sformatf("%s_done_c%0d", tag, c), {15'd0, done4},
          ((c == d1) || (c == d2)) ? 16'd1 : 16'd0);
    end
  endtask

  task automatic watch1(input string tag);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("%s_done_c%0d", tag, c), {15'd0, done1}, (c == 2) ? 16'd1 : 16'd0);
    end
  endtask

  initial begin
    n_err  = 0;
    n_chk  = 0;
    rst    = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    vin4   = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    bias4  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vin1   = '{16'h0000};
    bias1  = '{16'h0000};

    repeat (3) @(negedge clk);
    chk("rst_done4", {15'd0, done4}, 16'd0);
    chk("rst_done1", {15'd0, done1}, 16'd0);
    chk_out4("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("rst_out1", out1[0], 16'h0000);
    rst = 1'b0;

    // Main vector; inputs scrambled right after capture must not matter.
    @(negedge clk);
    vin4   = '{16'h3C00, 16'hC000, 16'h7BFF, 16'h3800};
    bias4  = '{16'h3800, 16'h3C00, 16'h7BFF, 16'hB800};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    vin4   = '{16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00};
    bias4  = '{16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00};
    watch4("t1", 1, 1, 5, -1);
    chk("t1_first_out0", out4[0], 16'h3E00);
    chk("t1_first_out1", out4[1], 16'h0000);
    watch4("t1", 2, 7, 5, -1);
    chk_out4("t1", 16'h3E00, NEG_M1, 16'h7C00, 16'h0000);

    // NaN propagation and Inf + -Inf; subnormal bias acts as zero.
    vin4   = '{16'h7E00, 16'h7C00, 16'h3C00, 16'h4000};
    bias4  = '{16'h3C00, 16'hFC00, 16'h0000, 16'h0001};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    watch4("t2", 1, 6, 5, -1);
    chk_out4("t2", 16'h7E00, 16'h7E00, 16'h3C00, 16'h4000);

    // start held high: one done per run, second capture right after DONE.
    vin4   = '{16'h4000, 16'h3C00, 16'h0001, 16'h0400};
    bias4  = '{16'h4000, 16'hBC00, 16'h0000, 16'h8400};
    start4 = 1'b1;
    @(negedge clk);
    vin4   = '{16'h3C00, 16'h4200, 16'hC400, 16'h7C00};
    watch4("t3", 1, 6, 5, 11);
    chk_out4("t3a", 16'h4400, 16'h0000, 16'h0000, 16'h0000);
    start4 = 1'b0;
    watch4("t3", 7, 13, 5, 11);
    chk_out4("t3b", 16'h4200, 16'h4000, NEG_M4, 16'h7C00);

    // Reset during RUN at idx 2 aborts without done.
    vin4   = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    bias4  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    watch4("t4", 1, 2, -1, -1);
    chk("t4_pre_out0", out4[0], 16'h4000);
    chk("t4_pre_out1", out4[1], 16'h4000);
    rst = 1'b1;
    #1;
    chk_out4("t4_rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("t4_rst_done", {15'd0, done4}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch4("t4r", 1, 8, -1, -1);
    chk_out4("t4r", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    vin4   = '{16'h3C00, 16'hC000, 16'h7BFF, 16'h3800};
    bias4  = '{16'h3800, 16'h3C00, 16'h7BFF, 16'hB800};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    watch4("t5", 1, 6, 5, -1);
    chk_out4("t5", 16'h3E00, NEG_M1, 16'h7C00, 16'h0000);

    // Single-element instance.
    vin1   = '{16'h3C00};
    bias1  = '{16'h3800};
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    watch1("h1a");
    chk("h1a_out0", out1[0], 16'h3E00);

    vin1   = '{16'hC000};
    bias1  = '{16'h3C00};
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    watch1("h1b");
    chk("h1b_out0", out1[0], NEG_M1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
